mpc_line_unpacker: RTL and testbench
====================================

// Module: mpc_line_unpacker
// PURPOSE
//  Front stage of the MPC decompressor. Accepts a compressed cache line as a stream of
//  64-bit beats, parses the header (pattern select + payload length) and gathers the
//  payload. Presents {select, 256-bit left-aligned payload} to the detransformer bank
//  and the pattern selector stage. Holds it under a valid/ready handshake.
// PARAMETERS
//  NUM_PATTERNS  8    number of compression patterns (0=all-zero, 1=wordsame, N-1=uncompressed)
//  LEN_ENCODE    3    $clog2(NUM_PATTERNS), width of select field
//  BEAT_W        64   input beat width (fixed; header layout depends on it)
//  LEN_W         9    payload-length field width (0..256 bits)
//  MAX_BEATS     5    ceil((LEN_ENCODE+LEN_W+256)/BEAT_W)
// PORTS
//  clk        in   1           clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid_i in   1           input beat valid
//  in_ready_o out  1           unpacker can accept a beat
//  in_data_i  in   BEAT_W      beat, MSB-first bitstream
//  out_valid_o out 1           parsed line valid
//  out_ready_i in  1           downstream accepts line
//  select_o   out  LEN_ENCODE  pattern select of line
//  data_o     out  256         payload, left-aligned at bit 255, zero below length
//  err_o      out  1           one-cycle pulse: illegal length field (clamped)
// BEHAVIOUR
//  Header = first beat [63:61] select, [60:52] len; payload starts at [51], continues
//   MSB-first through following beats. Last beat zero-padded. Lines never share beats.
//  Effective length L: sel 0 -> 0; sel 1 -> 32; sel NUM_PATTERNS-1 -> 256;
//   else len field. len>256 clamps L=256 and pulses err_o in the header cycle.
//  Beats per line B = ceil((12+L)/64): L=0..52 -> 1, 256 -> 5.
//  Handshake: beat transfers when in_valid_i&in_ready_o. Line transfers when
//   out_valid_o&out_ready_i. in_valid may drop between beats (stall, no loss).
//  FSM:
//   IDLE:    in_ready=1. Header beat -> load acc[319:256], capture select/L, cnt=1.
//            B==1 -> OUT else COLLECT.
//   COLLECT: in_ready=1. Each beat -> acc slot cnt (acc[319-64*cnt -: 64]), cnt++.
//            cnt reaches B -> OUT.
//   OUT:     in_ready=0, out_valid=1. select_o/data_o stable. out_ready -> IDLE.
//  data_o = acc[307:52] AND mask(L). mask has top L bits set, so pad and stale bits read 0.
//  Latency: out_valid rises the cycle after the last beat is accepted. Back-to-back
//   lines give B+1 cycles/line. No bypass of the OUT cycle.
//  out_valid held with out_ready=0 indefinitely: outputs frozen, input blocked.
//  Reset (any time, incl. mid-line): state=IDLE, cnt=0, acc=0, select_o=0,
//   out_valid_o=0, err_o=0, in_ready_o=1 after reset release. The partial line is discarded.
//  select_o/data_o valid only while out_valid_o=1. They hold their last value otherwise.
//  The accumulator is cleared on each header load.
// STRUCTURE
//  Shared package mpc_pkg: PAT_ZERO=0, PAT_WORDSAME=1, PAT_UNCOMP=NUM_PATTERNS-1,
//   HDR_W=12, LINE_W=256, BEAT_W, state enum {IDLE,COLLECT,OUT}, function
//   eff_len(sel,len) and beats(L).
//  One sub-module: mpc_payload_mask (combinational, L[8:0] -> 256-bit left-aligned mask).
//  Top holds FSM, beat counter, 320-bit accumulator and output registers.
// TESTING
//  1 all-zero: beat 64'h0000_0000_0000_0000 (sel 0) -> 1 beat, next cycle out_valid,
//    select_o=0, data_o=0.
//  2 wordsame: beat {3'd1,9'd0,32'hDEADBEEF,20'h0} -> select_o=1,
//    data_o[255:224]=DEADBEEF, rest 0.
//  3 uncompressed: sel 7, 5 beats of counting pattern with in_valid gaps -> data_o equals the
//    256-bit stream bits [307:52], pad ignored. out_valid exactly 1 cycle after beat 5.
//  4 transformer sel 3, len=100 -> B=2. Garbage in pad bits -> data_o top 100 bits match,
//    low 156 bits 0.
//  5 sel 4, len=300 -> err_o pulse in header cycle, L=256, B=5. Line completes normally.
//  6 backpressure+reset: hold out_ready=0 for 10 cycles -> in_ready=0 and outputs stable.
//    Then assert rst_n=0 mid-COLLECT of the next line -> out_valid=0. A fresh line after
//    release parses correctly.

Source files
------------

// File: rtl/mpc_pkg.sv
// Shared constants, FSM states and header-decode helpers for the MPC line unpacker.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mpc_pkg;

    localparam int NUM_PATTERNS = 8;
    localparam int LEN_ENCODE   = $clog2(NUM_PATTERNS);
    localparam int BEAT_W       = 64;
    localparam int LEN_W        = 9;
    localparam int HDR_W        = LEN_ENCODE + LEN_W;
    localparam int LINE_W       = 256;
    localparam int MAX_BEATS    = (HDR_W + LINE_W + BEAT_W - 1) / BEAT_W;
    localparam int CNT_W        = 3;
    localparam int SUM_W        = LEN_W + 1;

    localparam logic [LEN_ENCODE-1:0] PAT_ZERO     = LEN_ENCODE'(0);
    localparam logic [LEN_ENCODE-1:0] PAT_WORDSAME = LEN_ENCODE'(1);
    localparam logic [LEN_ENCODE-1:0] PAT_UNCOMP   = LEN_ENCODE'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

    // Effective payload length in bits; oversize length fields clamp to a full line.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_ENCODE-1:0] sel,
                                                 input logic [LEN_W-1:0]      len);
        if (sel == PAT_ZERO)
            return '0;
        else if (sel == PAT_WORDSAME)
            return LEN_W'(32);
        else if (sel == PAT_UNCOMP)
            return LEN_W'(LINE_W);
        else if (len > LEN_W'(LINE_W))
            return LEN_W'(LINE_W);
        else
            return len;
    endfunction

    // Only the transformer patterns carry a meaningful length field.
    function automatic logic len_illegal(input logic [LEN_ENCODE-1:0] sel,
                                         input logic [LEN_W-1:0]      len);
        return (sel != PAT_ZERO) && (sel != PAT_WORDSAME) && (sel != PAT_UNCOMP) &&
               (len > LEN_W'(LINE_W));
    endfunction

    // Beats occupied by a line: header plus payload, rounded up to whole beats.
    function automatic logic [CNT_W-1:0] beats(input logic [LEN_W-1:0] l);
        logic [SUM_W-1:0] bits;
        bits = SUM_W'(HDR_W) + {1'b0, l} + SUM_W'(BEAT_W - 1);
        return CNT_W'(bits / SUM_W'(BEAT_W));
    endfunction

endpackage

// File: rtl/mpc_line_unpacker_if.sv
// Beat-in / line-out handshake bundle of the MPC line unpacker.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides.
interface mpc_line_unpacker_if
    import mpc_pkg::*;
();
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [BEAT_W-1:0]     in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [LEN_ENCODE-1:0] select_o;
    logic [LINE_W-1:0]     data_o;
    logic                  err_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, select_o, data_o, err_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, select_o, data_o, err_o
    );
endinterface

// File: rtl/mpc_payload_mask.sv
// Left-aligned payload mask: top len_i bits of a line set, the rest clear.
// Latency: combinational.
// Backpressure: none.
module mpc_payload_mask
    import mpc_pkg::*;
(
    input  logic [LEN_W-1:0]  len_i,
    output logic [LINE_W-1:0] mask_o
);
    logic [LEN_W-1:0] shift;

    // Shift an all-ones line left so that len_i ones remain at the top; len 0 shifts all out.
    always_comb begin
        shift  = LEN_W'(LINE_W) - len_i;
        mask_o = {LINE_W{1'b1}} << shift;
    end
endmodule

// File: rtl/mpc_line_unpacker.sv
// Parses a compressed line from 64-bit beats into {select, left-aligned 256-bit payload}.
// Latency: line valid the cycle after its last beat is accepted; B+1 cycles per line.
// Backpressure: input blocked while a parsed line waits; output holds until out_ready_i.
module mpc_line_unpacker
    import mpc_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    mpc_line_unpacker_if.slave bus
);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      beats_q, beats_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_ENCODE-1:0] sel_q, sel_d;
    logic [LEN_ENCODE-1:0] sel_out_q, sel_out_d;
    logic [LINE_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;
    // Holds stream bits [307:52] of the 320-bit line window: the header and
    // the trailing pad of the last beat are never stored.
    logic [LINE_W-1:0]     acc_q, acc_d;

    logic [LEN_ENCODE-1:0] hdr_sel;
    logic [LEN_W-1:0]      hdr_len;
    logic [LEN_W-1:0]      hdr_l;
    logic [CNT_W-1:0]      hdr_b;
    logic [LEN_W-1:0]      mask_len;
    logic [LINE_W-1:0]     mask;
    logic                  in_ready;
    logic                  beat_fire;

    assign hdr_sel   = bus.in_data_i[BEAT_W-1 -: LEN_ENCODE];
    assign hdr_len   = bus.in_data_i[BEAT_W-LEN_ENCODE-1 -: LEN_W];
    assign hdr_l     = eff_len(hdr_sel, hdr_len);
    assign hdr_b     = beats(hdr_l);
    assign in_ready  = (state_q != OUT);
    assign beat_fire = bus.in_valid_i & in_ready;
    // A single-beat line finishes in the header cycle, before len_q is loaded.
    assign mask_len  = (state_q == IDLE) ? hdr_l : len_q;

    mpc_payload_mask u_mask (
        .len_i  (mask_len),
        .mask_o (mask)
    );

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == OUT);
    assign bus.select_o    = sel_out_q;
    assign bus.data_o      = data_q;
    assign bus.err_o       = err_q;

    // Next-state, beat gathering and output-register loading.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beats_d   = beats_q;
        len_d     = len_q;
        sel_d     = sel_q;
        sel_out_d = sel_out_q;
        data_d    = data_q;
        acc_d     = acc_q;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat_fire) begin
                    // Header load overwrites the whole accumulator, so stale payload never leaks.
                    acc_d   = {bus.in_data_i[BEAT_W-HDR_W-1:0], {(LINE_W-BEAT_W+HDR_W){1'b0}}};
                    cnt_d   = CNT_W'(1);
                    sel_d   = hdr_sel;
                    len_d   = hdr_l;
                    beats_d = hdr_b;
                    err_d   = len_illegal(hdr_sel, hdr_len);
                    if (hdr_b == CNT_W'(1)) begin
                        state_d   = OUT;
                        sel_out_d = hdr_sel;
                        data_d    = acc_d & mask;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (beat_fire) begin
                    // Beat k lands 52 + 64*(k-1) bits below the top of the payload.
                    case (cnt_q)
                        CNT_W'(1): acc_d[203:140] = bus.in_data_i;
                        CNT_W'(2): acc_d[139:76]  = bus.in_data_i;
                        CNT_W'(3): acc_d[75:12]   = bus.in_data_i;
                        default:   acc_d[11:0]    = bus.in_data_i[BEAT_W-1 -: 12];
                    endcase
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == beats_q) begin
                        state_d   = OUT;
                        sel_out_d = sel_q;
                        data_d    = acc_d & mask;
                    end
                end
            end
            OUT: begin
                if (bus.out_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partially gathered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            beats_q   <= '0;
            len_q     <= '0;
            sel_q     <= '0;
            sel_out_q <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beats_q   <= beats_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            sel_out_q <= sel_out_d;
            data_q    <= data_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_mpc_line_unpacker.sv
// Self-checking bench for mpc_line_unpacker: directed table, corner sequences, random lines.
// Latency: n/a (testbench).
// Backpressure: exercised with input gaps and output hold periods.
module tb_mpc_line_unpacker;
    import mpc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mpc_line_unpacker_if bus();

    mpc_line_unpacker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int sel;
        int len;
        int l;
        int b;
        int err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: the line format rules in plain integer arithmetic.
    function automatic int ref_len(input int sel, input int len);
        if (sel == 0) return 0;
        if (sel == 1) return 32;
        if (sel == NUM_PATTERNS - 1) return 256;
        return (len > 256) ? 256 : len;
    endfunction

    function automatic int ref_beats(input int l);
        return (12 + l + 63) / 64;
    endfunction

    function automatic int ref_err(input int sel, input int len);
        return (sel != 0 && sel != 1 && sel != NUM_PATTERNS - 1 && len > 256) ? 1 : 0;
    endfunction

    function automatic logic [255:0] ref_data(input logic [319:0] s, input int l);
        logic [255:0] p;
        p = s[307:52];
        for (int b = 0; b < 256; b++)
            if (b < 256 - l) p[b] = 1'b0;
        return p;
    endfunction

    function automatic logic [319:0] rand_stream(input int sel, input int len);
        logic [319:0] s;
        logic [2:0]   s3;
        logic [8:0]   l9;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        s3 = 3'(sel);
        l9 = 9'(len);
        s[319:308] = {s3, l9};
        return s;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Feeds one line, then checks latency, contents, err pulse, hold and release.
    task automatic run_line(input string name, input logic [319:0] s, input int l, input int nb,
                            input int exp_err, input int gap_max, input int hold);
        logic [2:0]   exp_sel;
        logic [255:0] exp_d;
        int           early;
        int           err_cnt;
        int           err_hdr;
        int           stable;
        int           g;
        exp_sel = s[319:317];
        exp_d   = ref_data(s, l);
        early   = 0;
        err_cnt = 0;
        err_hdr = 0;
        for (int i = 0; i < nb; i++) begin
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int k = 0; k < g; k++) begin
                bus.in_valid_i = 1'b0;
                bus.in_data_i  = {$urandom, $urandom};
                @(posedge clk);
                #1;
                if (bus.err_o) err_cnt++;
                if (bus.out_valid_o) early = 1;
            end
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = s[319-64*i -: 64];
            if (!bus.in_ready_o) early = 1;
            @(posedge clk);
            #1;
            if (bus.err_o) err_cnt++;
            if (i == 0) err_hdr = bus.err_o ? 1 : 0;
            if (i < nb - 1 && bus.out_valid_o) early = 1;
        end
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = {$urandom, $urandom};

        chk({name, ".beats"}, 256'(early), 256'(0));
        chk({name, ".latency"}, 256'(bus.out_valid_o), 256'(1));
        if (!bus.out_valid_o) begin
            do_reset();
            return;
        end
        chk({name, ".select"}, 256'(bus.select_o), 256'(exp_sel));
        chk({name, ".data"}, bus.data_o, exp_d);
        chk({name, ".err"}, 256'({err_hdr[0], 8'(err_cnt)}), 256'({exp_err[0], 8'(exp_err)}));

        stable = 1;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            if (bus.in_ready_o || !bus.out_valid_o || bus.select_o !== exp_sel ||
                bus.data_o !== exp_d || bus.err_o) stable = 0;
        end
        bus.in_valid_i = 1'b0;
        if (hold > 0) chk({name, ".hold"}, 256'(stable), 256'(1));

        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        chk({name, ".release"}, 256'({bus.out_valid_o, bus.in_ready_o, bus.select_o}),
            256'({1'b0, 1'b1, exp_sel}));
    endtask

    initial begin
        logic [319:0] s;
        int           sel;
        int           len;
        int           l;

        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;

        tbl[0]  = '{3, 100, 100, 2, 0};
        tbl[1]  = '{4, 300, 256, 5, 1};
        tbl[2]  = '{2, 52,  52,  1, 0};
        tbl[3]  = '{5, 53,  53,  2, 0};
        tbl[4]  = '{6, 256, 256, 5, 0};
        tbl[5]  = '{3, 0,   0,   1, 0};
        tbl[6]  = '{0, 200, 0,   1, 0};
        tbl[7]  = '{1, 511, 32,  1, 0};
        tbl[8]  = '{7, 400, 256, 5, 0};
        tbl[9]  = '{2, 116, 116, 2, 0};
        tbl[10] = '{2, 117, 117, 3, 0};
        tbl[11] = '{6, 257, 256, 5, 1};

        // Reset state.
        #12;
        chk("reset.ctrl", 256'({bus.out_valid_o, bus.in_ready_o, bus.err_o}), 256'(3'b010));
        chk("reset.select", 256'(bus.select_o), 256'(0));
        chk("reset.data", bus.data_o, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-zero line.
        run_line("t1_zero", 320'(0), 0, 1, 0, 0, 0);

        // Wordsame line.
        s = {3'd1, 9'd0, 32'hDEADBEEF, 20'h0, 256'h0};
        run_line("t2_wordsame", s, 32, 1, 0, 0, 0);
        chk("t2_const", bus.data_o, {32'hDEADBEEF, 224'h0});

        // Uncompressed counting pattern with input gaps.
        for (int j = 0; j < 40; j++) s[319-8*j -: 8] = 8'(j);
        s[319:308] = {3'd7, 9'd0};
        run_line("t3_uncomp", s, 256, 5, 0, 3, 0);

        // Directed table.
        for (int t = 0; t < 12; t++) begin
            s = rand_stream(tbl[t].sel, tbl[t].len);
            run_line($sformatf("tbl%0d", t), s, tbl[t].l, tbl[t].b, tbl[t].err, 1, t % 3);
        end

        // Backpressure for 10 cycles, then reset in the middle of collecting a line.
        s = rand_stream(3, 100);
        run_line("t6_bp", s, 100, 2, 0, 0, 10);
        s = rand_stream(7, 0);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = s[319:256];
        @(posedge clk);
        #1;
        bus.in_data_i  = s[255:192];
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst.ctrl", 256'({bus.out_valid_o, bus.in_ready_o, bus.err_o, bus.select_o}),
            256'({1'b0, 1'b1, 1'b0, 3'd0}));
        chk("t6_rst.data", bus.data_o, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s = rand_stream(5, 200);
        run_line("t6_fresh", s, 200, 4, 0, 1, 0);

        // Random lines against the reference model.
        for (int r = 0; r < 30; r++) begin
            sel = $urandom_range(7, 0);
            len = ($urandom_range(3, 0) == 0) ? $urandom_range(511, 257) : $urandom_range(256, 0);
            l   = ref_len(sel, len);
            s   = rand_stream(sel, len);
            run_line($sformatf("rnd%0d", r), s, l, ref_beats(l), ref_err(sel, len),
                     2, $urandom_range(3, 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
